clock_set_ctrl: RTL and testbench
=================================

# clock_set_ctrl

Controls time-setting for the DE0 nano clock. It synchronizes and debounces the four raw pushbuttons and runs a RUN/SET mode state machine. It arbitrates between the hours, minutes and seconds buttons and produces single-cycle increment pulses, with auto-repeat, for the time counters. It sits between the board pushbutton inputs and the seconds/minutes/hours counters in the clock, and gates their 1-second tick while the time is being set.

## Interface

Parameters:
- DB_CYCLES, 20: consecutive stable samples required before a debounced level change (20 ms at 1 kHz).
- RPT_DELAY, 500: cycles a button must be held after its first pulse before auto-repeat starts.
- RPT_PERIOD, 100: cycles between auto-repeat pulses.

Ports:
- clk_1ms  input  1  1 kHz system clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- raw_set_clk_button  input  1  raw pushbutton, active-low, asynchronous; toggles RUN/SET.
- raw_set_sec_button  input  1  raw pushbutton, active-low, asynchronous; increments seconds.
- raw_set_min_button  input  1  raw pushbutton, active-low, asynchronous; increments minutes.
- raw_set_hrs_button  input  1  raw pushbutton, active-low, asynchronous; increments hours.
- set_mode  output  1  1 while in SET state.
- run_en  output  1  enables the 1-sec tick to the time counters; the inverse of set_mode once out of reset.
- clr_sec  output  1  one-cycle pulse that zeroes the seconds counter.
- inc_sec  output  1  one-cycle increment pulse for the seconds counter.
- inc_min  output  1  one-cycle increment pulse for the minutes counter.
- inc_hrs  output  1  one-cycle increment pulse for the hours counter.

## Operation

**Input conditioning**
- Each raw button passes through a 2-flop synchronizer and is then inverted, so pressed = 1.
- Each button has its own debounce counter (ceil(log2(DB_CYCLES+1)) bits).
- The counter clears whenever the synchronized level equals the debounced level. Otherwise it increments.
- When the counter reaches DB_CYCLES-1 with the mismatch still present, the debounced level flips and the counter clears.
- A press event is a debounced 0->1 edge.

**Mode FSM (states RUN, SET)**
- RUN -> SET on a set_clk press event. A 1-cycle clr_sec pulse is issued together with the transition.
- SET -> RUN on a set_clk press event.
- Releases of set_clk are ignored.

**Increment arbiter (active in SET only)**
- State IDLE: if any of hrs/min/sec is debounced-pressed, grant the highest-priority one (hrs > min > sec), issue one inc pulse for it, and go to HOLD.
- State HOLD: only the granted button is serviced; the others are ignored.
- While it is still held, a 10-bit repeat counter runs. The first repeat pulse comes RPT_DELAY cycles after the initial pulse, then one every RPT_PERIOD cycles.
- When the granted button is released, wait in LOCK until all three buttons are released, then return to IDLE. A lower-priority button held throughout therefore produces no pulse until it is re-pressed.
- In RUN, the arbiter is forced to IDLE and inc_* stay 0. A button held across the RUN -> SET transition is treated as a new press on the first SET cycle.
- A SET -> RUN transition mid-HOLD aborts immediately: no further pulses, arbiter to IDLE.

**Output rules**
- All outputs are registered.
- At most one of inc_sec/inc_min/inc_hrs is high in any cycle.
- clr_sec and inc_sec are never high in the same cycle. If the entry cycle also grants sec, the inc is deferred one cycle.

## Timing

- Reset values (applied on any clk_1ms edge with reset=1, including mid-operation): set_mode=0, run_en=0, clr_sec=0, inc_*=0.
  - Synchronizers, debounced levels (released) and all counters are cleared; FSM goes to RUN, arbiter to IDLE.
  - run_en=1 from the first edge after reset deasserts.
- Press latency: a raw falling edge first sampled at edge N gives a debounced edge at N+DB_CYCLES+1, and the corresponding output (mode change or inc pulse) at edge N+DB_CYCLES+2. That is DB_CYCLES+2 cycles with no bounce.
- Bounce shorter than DB_CYCLES cycles never changes the debounced level. Each bounce restarts the count.
- Repeat pulse spacing: first to second = RPT_DELAY cycles; thereafter RPT_PERIOD cycles. The repeat counter saturates and does not wrap.
- set_mode and run_en change on the same edge as the FSM transition.

## Test plan

1. **Reset and run_en.** Hold reset for 5 cycles, then release → all outputs 0 during reset; run_en=1 one cycle after release, set_mode=0.
2. **Bounce rejection.** Toggle raw_set_clk_button low/high every 5 cycles for 100 cycles, then hold low 40 cycles → exactly one set_mode 0->1 transition, 22 cycles after the start of the final stable low; clr_sec pulses once on that same edge; run_en=0.
3. **Auto-repeat.** In SET, hold raw_set_min_button low for 800 cycles → inc_min pulses at t0, t0+500, t0+600, t0+700 (4 pulses); no inc_sec/inc_hrs.
4. **Priority and lock-out.** In SET, press sec and hrs on the same cycle, release hrs after 50 cycles and keep sec held → exactly one inc_hrs; no inc_sec until sec is released and re-pressed, then one inc_sec.
5. **Leaving SET mid-hold.** In SET, hold hrs and press set_clk 300 cycles into the hold → set_mode=0, run_en=1; no further inc_hrs pulses.
6. **Reset mid-operation.** Assert reset during a HOLD with a min repeat pending → no inc_min after reset. After release, with the button still held, the FSM is in RUN and no pulses occur.

Source files
------------

// File: rtl/clock_set_ctrl.sv
// Time-setting front end for the DE0 nano clock: button conditioning, RUN/SET
// mode control and an hrs > min > sec increment arbiter with auto-repeat.
module clock_set_ctrl #(
    parameter int unsigned DB_CYCLES  = 20,
    parameter int unsigned RPT_DELAY  = 500,
    parameter int unsigned RPT_PERIOD = 100
) (
    input  logic clk_1ms,
    input  logic reset,
    input  logic raw_set_clk_button,
    input  logic raw_set_sec_button,
    input  logic raw_set_min_button,
    input  logic raw_set_hrs_button,
    output logic set_mode,
    output logic run_en,
    output logic clr_sec,
    output logic inc_sec,
    output logic inc_min,
    output logic inc_hrs
);

    localparam int unsigned DBW = $clog2(DB_CYCLES + 1);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);
    localparam logic [9:0] DELAY_LAST  = 10'(RPT_DELAY - 1);
    localparam logic [9:0] PERIOD_LAST = 10'(RPT_PERIOD - 1);
    localparam logic [9:0] RPT_MAX     = 10'h3FF;

    typedef enum logic {RUN, SET} mode_t;
    typedef enum logic [1:0] {IDLE, HOLD, LOCK} arb_t;

    // Button index: 0 = set_clk, 1 = sec, 2 = min, 3 = hrs.
    logic [3:0]     raw;
    logic [3:0]     sync1;
    logic [3:0]     sync2;
    logic [3:0]     deb;
    logic [DBW-1:0] db_cnt [4];
    logic           clk_deb_prev;
    logic           clk_press;
    mode_t          mode;
    arb_t           arb;
    logic [1:0]     grant;
    logic [9:0]     rpt_cnt;
    logic           repeating;

    assign raw       = {raw_set_hrs_button, raw_set_min_button, raw_set_sec_button, raw_set_clk_button};
    assign clk_press = deb[0] & ~clk_deb_prev;

    // Two-flop synchronizers; idle (released) level is high on the raw side.
    always_ff @(posedge clk_1ms) begin
        if (reset) begin
            sync1 <= 4'hF;
            sync2 <= 4'hF;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Per-button debounce: the level flips only after DB_CYCLES consecutive mismatching samples.
    always_ff @(posedge clk_1ms) begin
        for (int i = 0; i < 4; i++) begin
            if (reset) begin
                db_cnt[i] <= '0;
                deb[i]    <= 1'b0;
            end else if (~sync2[i] == deb[i]) begin
                db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
                deb[i]    <= ~deb[i];
                db_cnt[i] <= '0;
            end else begin
                db_cnt[i] <= db_cnt[i] + DBW'(1);
            end
        end
    end

    // RUN/SET mode machine; entering SET also zeroes the seconds counter.
    always_ff @(posedge clk_1ms) begin
        if (reset) begin
            clk_deb_prev <= 1'b0;
            mode         <= RUN;
            set_mode     <= 1'b0;
            run_en       <= 1'b0;
            clr_sec      <= 1'b0;
        end else begin
            clk_deb_prev <= deb[0];
            clr_sec      <= 1'b0;
            case (mode)
                RUN: begin
                    if (clk_press) begin
                        mode     <= SET;
                        set_mode <= 1'b1;
                        run_en   <= 1'b0;
                        clr_sec  <= 1'b1;
                    end else begin
                        set_mode <= 1'b0;
                        run_en   <= 1'b1;
                    end
                end
                SET: begin
                    if (clk_press) begin
                        mode     <= RUN;
                        set_mode <= 1'b0;
                        run_en   <= 1'b1;
                    end else begin
                        set_mode <= 1'b1;
                        run_en   <= 1'b0;
                    end
                end
                default: begin
                    mode     <= RUN;
                    set_mode <= 1'b0;
                    run_en   <= 1'b1;
                end
            endcase
        end
    end

    // Increment arbiter. The entry edge sees mode==RUN, so a sec grant lands
    // one cycle after clr_sec and the two never coincide.
    always_ff @(posedge clk_1ms) begin
        if (reset) begin
            arb       <= IDLE;
            grant     <= 2'd0;
            rpt_cnt   <= 10'd0;
            repeating <= 1'b0;
            inc_sec   <= 1'b0;
            inc_min   <= 1'b0;
            inc_hrs   <= 1'b0;
        end else begin
            inc_sec <= 1'b0;
            inc_min <= 1'b0;
            inc_hrs <= 1'b0;
            if (mode != SET || clk_press) begin
                arb     <= IDLE;
                rpt_cnt <= 10'd0;
            end else begin
                case (arb)
                    IDLE: begin
                        rpt_cnt   <= 10'd0;
                        repeating <= 1'b0;
                        if (deb[3]) begin
                            grant   <= 2'd3;
                            inc_hrs <= 1'b1;
                            arb     <= HOLD;
                        end else if (deb[2]) begin
                            grant   <= 2'd2;
                            inc_min <= 1'b1;
                            arb     <= HOLD;
                        end else if (deb[1]) begin
                            grant   <= 2'd1;
                            inc_sec <= 1'b1;
                            arb     <= HOLD;
                        end else begin
                            arb <= IDLE;
                        end
                    end
                    HOLD: begin
                        if (!deb[grant]) begin
                            arb <= LOCK;
                        end else if (rpt_cnt == (repeating ? PERIOD_LAST : DELAY_LAST)) begin
                            inc_sec   <= (grant == 2'd1);
                            inc_min   <= (grant == 2'd2);
                            inc_hrs   <= (grant == 2'd3);
                            rpt_cnt   <= 10'd0;
                            repeating <= 1'b1;
                        end else if (rpt_cnt != RPT_MAX) begin
                            rpt_cnt <= rpt_cnt + 10'd1;
                        end else begin
                            rpt_cnt <= rpt_cnt;
                        end
                    end
                    LOCK: begin
                        if (deb[3:1] == 3'b000) begin
                            arb <= IDLE;
                        end else begin
                            arb <= LOCK;
                        end
                    end
                    default: arb <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Scoreboard bench for clock_set_ctrl: a per-edge behavioural model queues the
// expected output events; a negedge monitor pops and compares them.
module tb_clock_set_ctrl;

    localparam int DB   = 20;
    localparam int RD   = 500;
    localparam int RP   = 100;

    logic       clk;
    logic       reset;
    logic [3:0] raw_b;
    logic       set_mode, run_en, clr_sec, inc_sec, inc_min, inc_hrs;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    clock_set_ctrl #(.DB_CYCLES(DB), .RPT_DELAY(RD), .RPT_PERIOD(RP)) dut (
        .clk_1ms(clk),
        .reset(reset),
        .raw_set_clk_button(raw_b[0]),
        .raw_set_sec_button(raw_b[1]),
        .raw_set_min_button(raw_b[2]),
        .raw_set_hrs_button(raw_b[3]),
        .set_mode(set_mode),
        .run_en(run_en),
        .clr_sec(clr_sec),
        .inc_sec(inc_sec),
        .inc_min(inc_min),
        .inc_hrs(inc_hrs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {int c; bit [5:0] v;} ev_t;
    ev_t sb[$];

    // Reference model: synchronizer as a 2-deep delay, debounce as "the last DB
    // samples all disagree with the level", repeat timing from elapsed cycles.
    bit [3:0] m_s1 = 4'hF, m_s2 = 4'hF, m_deb = 4'h0, m_debo = 4'h0;
    bit       m_win [4][DB];
    bit       m_set = 1'b0;
    int       m_st = 0, m_g = 0, m_last = 0, m_n = 0;
    bit [5:0] m_prev = 6'd0;

    always @(posedge clk) begin
        bit [3:0] prs;
        bit [3:0] dold;
        bit [2:0] inc;
        bit [5:0] v;
        bit       clr;
        bit       all;
        cyc++;
        v = 6'd0;
        if (reset) begin
            m_s1 = 4'hF; m_s2 = 4'hF; m_deb = 4'h0; m_debo = 4'h0;
            for (int b = 0; b < 4; b++)
                for (int k = 0; k < DB; k++) m_win[b][k] = 1'b0;
            m_set = 1'b0; m_st = 0;
        end else begin
            prs = m_deb & ~m_debo;
            inc = 3'b000;
            clr = 1'b0;
            if (!m_set || prs[0]) m_st = 0;
            else if (m_st == 0) begin
                for (int b = 3; b >= 1; b--)
                    if (m_deb[b] && m_st == 0) begin
                        m_g = b; m_st = 1; m_last = cyc; m_n = 1; inc[b-1] = 1'b1;
                    end
            end else if (m_st == 1) begin
                if (!m_deb[m_g]) m_st = 2;
                else if (cyc - m_last == ((m_n == 1) ? RD : RP)) begin
                    inc[m_g-1] = 1'b1; m_last = cyc; m_n++;
                end
            end else if (m_deb[3:1] == 3'b000) m_st = 0;
            if (prs[0]) begin
                clr = !m_set;
                m_set = !m_set;
            end
            v = {m_set, !m_set, clr, inc[0], inc[1], inc[2]};
            dold = m_deb;
            for (int b = 0; b < 4; b++) begin
                for (int k = DB - 1; k > 0; k--) m_win[b][k] = m_win[b][k-1];
                m_win[b][0] = !m_s2[b];
                all = 1'b1;
                for (int k = 0; k < DB; k++) if (m_win[b][k] == m_deb[b]) all = 1'b0;
                if (all) m_deb[b] = !m_deb[b];
            end
            m_debo = dold;
            m_s2 = m_s1;
            m_s1 = raw_b;
        end
        if (v != m_prev || v[3:0] != 4'd0) sb.push_back('{cyc, v});
        m_prev = v;
    end

    // Monitor: any output change or pulse is a DUT event matched against the queue.
    bit [5:0] d_prev = 6'd0;
    int n_sec = 0, n_min = 0, n_hrs = 0, n_clr = 0, n_rise = 0, rise_cyc = -1;

    always @(negedge clk) begin
        bit [5:0] dv;
        ev_t e;
        if (cyc > 0) begin
            dv = {set_mode, run_en, clr_sec, inc_sec, inc_min, inc_hrs};
            if (dv != d_prev || dv[3:0] != 4'd0) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected: got outputs %b with nothing expected (cycle %0d)", dv, cyc);
                end else begin
                    e = sb.pop_front();
                    check("sb_cycle", cyc, e.c);
                    check("sb_outputs", int'(dv), int'(e.v));
                end
            end
            if (inc_sec) n_sec++;
            if (inc_min) n_min++;
            if (inc_hrs) n_hrs++;
            if (clr_sec) n_clr++;
            if (set_mode && !d_prev[5]) begin
                n_rise++;
                rise_cyc = cyc;
            end
            d_prev = dv;
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tap_clk();
        raw_b[0] = 1'b0;
        wait_cyc(30);
        raw_b[0] = 1'b1;
        wait_cyc(30);
    endtask

    int t, d, d2, n_start, b_sec, b_min, b_hrs, b_clr, b_rise;

    initial begin
        reset = 1'b1;
        raw_b = 4'hF;
        wait_cyc(5);
        #1;
        check("rst_outputs", int'({set_mode, run_en, clr_sec, inc_sec, inc_min, inc_hrs}), 0);
        reset = 1'b0;
        wait_cyc(1);
        #1;
        check("rst_run_en", int'(run_en), 1);
        check("rst_set_mode", int'(set_mode), 0);

        // Bounce rejection then a clean press.
        b_rise = n_rise; b_clr = n_clr;
        t = 0;
        while (t < 100) begin
            d  = $urandom_range(1, 15);
            d2 = $urandom_range(1, 15);
            raw_b[0] = 1'b0; wait_cyc(d);
            raw_b[0] = 1'b1; wait_cyc(d2);
            t += d + d2;
        end
        raw_b[0] = 1'b0;
        n_start  = cyc + 1;
        wait_cyc(40);
        raw_b[0] = 1'b1;
        wait_cyc(30);
        #1;
        check("bounce_rises", n_rise - b_rise, 1);
        check("bounce_latency", rise_cyc, n_start + DB + 2);
        check("bounce_clr", n_clr - b_clr, 1);
        check("bounce_run_en", int'(run_en), 0);

        // Auto-repeat on minutes.
        b_sec = n_sec; b_min = n_min; b_hrs = n_hrs;
        raw_b[2] = 1'b0; wait_cyc(800);
        raw_b[2] = 1'b1; wait_cyc(40);
        #1;
        check("rpt_min", n_min - b_min, 4);
        check("rpt_others", (n_sec - b_sec) + (n_hrs - b_hrs), 0);

        // Priority and lock-out.
        b_sec = n_sec; b_hrs = n_hrs;
        raw_b[1] = 1'b0; raw_b[3] = 1'b0; wait_cyc(50);
        raw_b[3] = 1'b1; wait_cyc(100);
        #1;
        check("prio_hrs", n_hrs - b_hrs, 1);
        check("prio_sec_locked", n_sec - b_sec, 0);
        raw_b[1] = 1'b1; wait_cyc(40);
        raw_b[1] = 1'b0; wait_cyc(40);
        raw_b[1] = 1'b1; wait_cyc(40);
        #1;
        check("prio_sec_repress", n_sec - b_sec, 1);

        // Leaving SET in the middle of a hold.
        b_hrs = n_hrs;
        raw_b[3] = 1'b0; wait_cyc(DB + 2 + 300);
        tap_clk();
        wait_cyc(400);
        #1;
        check("exit_hrs", n_hrs - b_hrs, 1);
        check("exit_set_mode", int'(set_mode), 0);
        check("exit_run_en", int'(run_en), 1);
        raw_b[3] = 1'b1; wait_cyc(40);

        // Reset during a hold with a repeat pending.
        tap_clk();
        b_min = n_min;
        raw_b[2] = 1'b0; wait_cyc(DB + 2 + 300);
        reset = 1'b1; wait_cyc(5);
        reset = 1'b0; wait_cyc(700);
        #1;
        check("rst_hold_min", n_min - b_min, 1);
        check("rst_hold_set_mode", int'(set_mode), 0);
        check("rst_hold_run_en", int'(run_en), 1);
        raw_b[2] = 1'b1; wait_cyc(40);

        // Randomized activity against the model.
        for (int s = 0; s < 40; s++) begin
            raw_b[3:1] = 3'($urandom);
            raw_b[0]   = ($urandom_range(0, 5) == 0) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 19) == 0) reset = 1'b1;
            wait_cyc($urandom_range(1, 3));
            reset = 1'b0;
            wait_cyc($urandom_range(1, 300));
        end
        raw_b = 4'hF;
        wait_cyc(60);
        #1;
        check("sb_drain", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
